// File: rtl/apu_frame_sequencer.sv
// APU frame counter: quarter/half-frame strobes, $4017 mode/inhibit register, frame interrupt.
// Build option FRAME_SEQ_IRQ_EN enables the frame IRQ flag, n_IRQ and the $4015 DB[6] readback.
module apu_frame_sequencer #(
  parameter int unsigned CNT_W = 15,
  parameter int unsigned STEP1 = 3728,
  parameter int unsigned STEP2 = 7456,
  parameter int unsigned STEP3 = 11185,
  parameter int unsigned STEP4 = 14914,
  parameter int unsigned STEP5 = 18640
) (
  input  logic       n_ACLK,
  input  logic       n_RES,
  input  logic       W4017,
  input  logic       n_R4015,
  inout  wire  [7:0] DB,
  output logic       nLFO1,
  output logic       nLFO2,
  output logic       n_IRQ
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             wr_pend_q, wr_pend_d;
  logic             lfo1_q, lfo1_d;
  logic             lfo2_q, lfo2_d;

  logic hit1, hit2, hit3, hit4, hit5;
  logic at_last;
  logic step_qtr;
  logic step_half;
  logic irq_set;

  // Step decode; 5-step mode ignores STEP4 and ends the frame at STEP5.
  always_comb begin
    hit1      = (cnt_q == S1);
    hit2      = (cnt_q == S2);
    hit3      = (cnt_q == S3);
    hit4      = (cnt_q == S4);
    hit5      = (cnt_q == S5);
    at_last   = mode_q ? (cnt_q >= S5) : (cnt_q >= S4);
    step_qtr  = hit1 | hit2 | hit3 | (mode_q ? hit5 : hit4);
    step_half = hit2 | (mode_q ? hit5 : hit4);
    irq_set   = !mode_q && hit4 && !inhibit_q;
  end

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    wr_pend_d = 1'b0;
    if (wr_pend_q || at_last) begin
      cnt_d = '0;
    end
    // A write on the restart edge re-arms the restart for the following edge.
    if (W4017) begin
      mode_d    = DB[7];
      inhibit_d = DB[6];
      wr_pend_d = 1'b1;
    end
    // Restart into 5-step mode clocks both units immediately, merged with any step event.
    lfo1_d = step_qtr  | (wr_pend_q & mode_q);
    lfo2_d = step_half | (wr_pend_q & mode_q);
  end

  always_ff @(posedge n_ACLK or negedge n_RES) begin
    if (!n_RES) begin
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      wr_pend_q <= 1'b0;
      lfo1_q    <= 1'b0;
      lfo2_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      wr_pend_q <= wr_pend_d;
      lfo1_q    <= lfo1_d;
      lfo2_q    <= lfo2_d;
    end
  end

  assign nLFO1 = ~lfo1_q;
  assign nLFO2 = ~lfo2_q;

`ifdef FRAME_SEQ_IRQ_EN
  logic flag_q, flag_d;

  // Read clear < frame set < inhibit-write clear.
  always_comb begin
    flag_d = flag_q;
    if (!n_R4015) begin
      flag_d = 1'b0;
    end
    if (irq_set) begin
      flag_d = 1'b1;
    end
    if (W4017 && DB[6]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge n_ACLK or negedge n_RES) begin
    if (!n_RES) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign n_IRQ = ~flag_q;
  assign DB[6] = n_R4015 ? 1'bz : flag_q;
`else
  logic unused_irq;
  assign unused_irq = ^{n_R4015, irq_set};
  assign n_IRQ      = 1'b1;
`endif

  logic unused_db;
  assign unused_db = ^DB[5:0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: table of timed vectors with expected strobe counts and levels,
// plus hand-written reset sequences. IRQ expectations follow the FRAME_SEQ_IRQ_EN build option.
module tb_apu_frame_sequencer;

`ifdef FRAME_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int W  = 10;
  localparam int NV = 21;

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;

  // op is applied on the last edge of the advance; counts cover every sample of the advance.
  typedef struct {
    op_e         op;
    logic [7:0]  data;
    int unsigned adv;
    int unsigned l1_cnt;
    int unsigned l2_cnt;
    logic        l1;
    logic        l2;
    logic        irq;
    logic        db6;
  } vec_t;

  logic       n_aclk = 1'b0;
  logic       n_res;
  logic       w4017;
  logic       n_r4015;
  logic [7:0] tb_db;
  logic       tb_db_oe;
  wire  [7:0] db;
  logic       nlfo1;
  logic       nlfo2;
  logic       n_irq;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[NV];
  int           n_vec;
  int           n_err;

  assign db = tb_db_oe ? tb_db : 8'bz;

  apu_frame_sequencer dut (
    .n_ACLK (n_aclk),
    .n_RES  (n_res),
    .W4017  (w4017),
    .n_R4015(n_r4015),
    .DB     (db),
    .nLFO1  (nlfo1),
    .nLFO2  (nlfo2),
    .n_IRQ  (n_irq)
  );

  always #5 n_aclk = ~n_aclk;

  function automatic vec_t mk(input op_e op, input logic [7:0] data, input int unsigned adv,
                              input int unsigned c1, input int unsigned c2,
                              input logic l1, input logic l2, input logic irq, input logic db6);
    vec_t v;
    v.op = op;  v.data = data; v.adv = adv;
    v.l1_cnt = c1; v.l2_cnt = c2;
    v.l1 = l1; v.l2 = l2; v.irq = irq; v.db6 = db6;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp_v, $time);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t         v;
    int           c1;
    int           c2;
    logic         s_db6;
    logic [W-1:0] e;
    v     = vecs[i];
    c1    = 0;
    c2    = 0;
    s_db6 = 1'b0;
    exp_q.push_back({3'(v.l1_cnt), 3'(v.l2_cnt), v.l1, v.l2,
                     (IRQ_EN ? v.irq : 1'b1), (IRQ_EN & v.db6)});
    for (int k = 0; k < int'(v.adv); k++) begin
      if (k == int'(v.adv) - 1) begin
        if (v.op == OP_WRITE) begin
          w4017    = 1'b1;
          tb_db    = v.data;
          tb_db_oe = 1'b1;
        end else if (v.op == OP_READ) begin
          n_r4015 = 1'b0;
          #1;
          s_db6 = (db[6] === 1'b1);
        end
      end
      @(posedge n_aclk);
      @(negedge n_aclk);
      w4017    = 1'b0;
      tb_db_oe = 1'b0;
      n_r4015  = 1'b1;
      if (!nlfo1) c1++;
      if (!nlfo2) c2++;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d nLFO1 low count", i), c1, int'(e[9:7]));
    check($sformatf("v%0d nLFO2 low count", i), c2, int'(e[6:4]));
    check($sformatf("v%0d nLFO1", i), int'(nlfo1), int'(e[3]));
    check($sformatf("v%0d nLFO2", i), int'(nlfo2), int'(e[2]));
    check($sformatf("v%0d n_IRQ", i), int'(n_irq), int'(e[1]));
    if (v.op == OP_READ) begin
      check($sformatf("v%0d DB[6] read", i), int'(s_db6), int'(e[0]));
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_res    = 1'b1;
    w4017    = 1'b0;
    n_r4015  = 1'b1;
    tb_db    = 8'h00;
    tb_db_oe = 1'b0;

    // Power-up into mode 0, then 00 write followed by an 80 write on the restart edge.
    vecs[0]  = mk(OP_IDLE,  8'h00, 0,     0, 0, 1, 1, 1, 0);
    vecs[1]  = mk(OP_WRITE, 8'h00, 1,     0, 0, 1, 1, 1, 0);
    vecs[2]  = mk(OP_WRITE, 8'h80, 1,     0, 0, 1, 1, 1, 0);
    vecs[3]  = mk(OP_IDLE,  8'h00, 1,     1, 1, 0, 0, 1, 0);
    // 5-step frame: 3728, 7456, 11185, nothing at 14914, 18640.
    vecs[4]  = mk(OP_IDLE,  8'h00, 3729,  1, 0, 0, 1, 1, 0);
    vecs[5]  = mk(OP_IDLE,  8'h00, 3728,  1, 1, 0, 0, 1, 0);
    vecs[6]  = mk(OP_IDLE,  8'h00, 3729,  1, 0, 0, 1, 1, 0);
    vecs[7]  = mk(OP_IDLE,  8'h00, 3729,  0, 0, 1, 1, 1, 0);
    vecs[8]  = mk(OP_IDLE,  8'h00, 3726,  1, 1, 0, 0, 1, 0);
    vecs[9]  = mk(OP_IDLE,  8'h00, 7457,  2, 1, 0, 0, 1, 0);
    // After mid-frame reset: 4-step frame with IRQ at 14914.
    vecs[10] = mk(OP_IDLE,  8'h00, 3729,  1, 0, 0, 1, 1, 0);
    vecs[11] = mk(OP_IDLE,  8'h00, 3728,  1, 1, 0, 0, 1, 0);
    vecs[12] = mk(OP_IDLE,  8'h00, 3729,  1, 0, 0, 1, 1, 0);
    vecs[13] = mk(OP_IDLE,  8'h00, 3729,  1, 1, 0, 0, 0, 0);
    vecs[14] = mk(OP_IDLE,  8'h00, 1,     0, 0, 1, 1, 0, 0);
    vecs[15] = mk(OP_READ,  8'h00, 1,     0, 0, 1, 1, 1, 1);
    // Read on the STEP4 edge: set wins.
    vecs[16] = mk(OP_READ,  8'h00, 14913, 4, 2, 0, 0, 0, 0);
    // Inhibit write clears the flag and blocks the next frame's set.
    vecs[17] = mk(OP_WRITE, 8'h40, 1,     0, 0, 1, 1, 1, 0);
    vecs[18] = mk(OP_IDLE,  8'h00, 1,     0, 0, 1, 1, 1, 0);
    vecs[19] = mk(OP_IDLE,  8'h00, 14915, 4, 2, 0, 0, 1, 0);
    vecs[20] = mk(OP_IDLE,  8'h00, 1,     0, 0, 1, 1, 1, 0);

    #2 n_res = 1'b0;
    #1;
    check("reset nLFO1", int'(nlfo1), 1);
    check("reset nLFO2", int'(nlfo2), 1);
    check("reset n_IRQ", int'(n_irq), 1);
    @(negedge n_aclk);
    @(negedge n_aclk);
    n_res = 1'b1;

    for (int i = 0; i <= 9; i++) run_vec(i);

    // Asynchronous reset while both strobes are low in 5-step mode.
    #2 n_res = 1'b0;
    #1;
    check("midframe reset nLFO1", int'(nlfo1), 1);
    check("midframe reset nLFO2", int'(nlfo2), 1);
    check("midframe reset n_IRQ", int'(n_irq), 1);
    @(negedge n_aclk);
    n_res = 1'b1;

    for (int i = 10; i < NV; i++) run_vec(i);

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
